// File: rtl/npu.sv
// npu: single-layer Q16.16 neural-network accelerator on a shared 32-bit bus.
// Host sequence: one start word, one START-cycle word, six config words,
// then per output neuron j the weights w[j][0..num_in] and bias b[j], then
// num_in+1 inputs. Each input is MAC'd into all active PEs as it arrives;
// bias and optional ReLU follow, then the results are read back with oe.
// Ports: clk/rst (async active-low), we/oe host strobes, data (inout bus,
// driven only while oe && ready && !we), ready, and a set of debug taps of
// the FSM, pointers, PE0 datapath and buffer heads.

// One PE per output neuron: accumulates (x*w)>>>16 during input streaming,
// then adds the bias. Product is full 64-bit signed; the sum wraps at 32 bits.
module npu_pe (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        mac_en_i,
  input  logic        bias_en_i,
  input  logic [31:0] x_i,
  input  logic [31:0] w_i,
  input  logic [31:0] b_i,
  output logic [31:0] acc_o
);
  logic signed [63:0] prod;
  logic        [31:0] acc_q, acc_d;

  always_comb begin
    prod  = $signed({{32{x_i[31]}}, x_i}) * $signed({{32{w_i[31]}}, w_i});
    acc_d = acc_q;
    if (clr_i)          acc_d = '0;
    else if (mac_en_i)  acc_d = acc_q + 32'(prod >>> 16);
    else if (bias_en_i) acc_d = acc_q + b_i;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;

  assign acc_o = acc_q;
endmodule

module npu #(
  parameter int NUM_PE    = 8,
  parameter int MAX_IN    = 32,
  parameter int WGT_DEPTH = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        oe,
  inout  wire  [31:0] data,
  output logic        ready,
  output logic [2:0]  pe_state_r0,
  output logic [3:0]  state_r,
  output logic [1:0]  num_layers_r,
  output logic [4:0]  num_neurons_r3,
  output logic [5:0]  num_multadds,
  output logic [4:0]  state_count_r,
  output logic [5:0]  multadd_count_r,
  output logic [31:0] fp_mac_a,
  output logic [31:0] fp_mac_b,
  output logic [31:0] fp_mac_output,
  output logic [4:0]  counter,
  output logic        fp_mac_acc,
  output logic [$clog2(WGT_DEPTH)-1:0] ArrWgt_Rd,
  output logic [$clog2(WGT_DEPTH)-1:0] ArrWgt_Wr,
  output logic [4:0]  InBuf_Rd,
  output logic [4:0]  InBuf_Wr,
  output logic [4:0]  OutBuf_Rd,
  output logic [4:0]  OutBuf_Wr,
  output logic        pe_oe_0,
  output logic [31:0] InBuf_i0,
  output logic [31:0] ArrWeights_i0,
  output logic [31:0] ArrWeights_i1,
  output logic [31:0] OutBuf_i0,
  output logic [31:0] OutBuf_n_i0,
  output logic        OutBuf_Full
);
  localparam int PW   = $clog2(NUM_PE);
  localparam int AW   = $clog2(WGT_DEPTH);
  localparam int WDEP = MAX_IN + 2;   // weights plus bias slot per PE

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_START = 4'd1, S_CFG = 4'd2, S_LOADW = 4'd3,
    S_LOADIN = 4'd4, S_BIAS = 4'd5, S_ACT = 4'd6, S_DONE = 4'd7
  } state_t;
  typedef enum logic [2:0] {
    PE_IDLE = 3'd0, PE_LOAD = 3'd1, PE_MA = 3'd2, PE_BIAS = 3'd5, PE_ACT = 3'd6
  } pe_state_t;

  state_t      state_q;
  pe_state_t   pe_state_q;
  logic        ready_q, full_q, act_q;
  logic [1:0]  num_layers_q;
  logic [4:0]  num_in_q, num_out_q, cnt_q, pe_cnt_q;
  logic [4:0]  inwr_q, inrd_q, outrd_q, outwr_q;
  logic [5:0]  mac_cnt_q, wcol_q, bias_idx;
  logic [AW-1:0] wwr_q;
  logic [31:0] inbuf_q  [MAX_IN];
  logic [31:0] wmem_q   [NUM_PE][WDEP];
  logic [31:0] outbuf_q [NUM_PE];
  logic [NUM_PE-1:0][31:0] acc, res;
  logic start_tx, mac_en, bias_en, act_en, drive;

  assign start_tx = we && (state_q == S_IDLE || state_q == S_DONE);
  assign mac_en   = we && (state_q == S_LOADIN);
  assign bias_en  = (state_q == S_BIAS);
  assign act_en   = (state_q == S_ACT);
  assign bias_idx = 6'(num_in_q) + 6'd1;
  // we has priority over oe on the shared bus
  assign drive    = oe && !we && ready_q;
  assign data     = drive ? outbuf_q[outrd_q[PW-1:0]] : 'z;

  for (genvar j = 0; j < NUM_PE; j++) begin : g_pe
    logic act_j;
    assign act_j = (5'(j) <= num_out_q);
    npu_pe u_pe (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (start_tx),
      .mac_en_i  (mac_en && act_j),
      .bias_en_i (bias_en && act_j),
      .x_i       (data),
      .w_i       (wmem_q[j][mac_cnt_q]),
      .b_i       (wmem_q[j][bias_idx]),
      .acc_o     (acc[j])
    );
    assign res[j] = (act_q && acc[j][31]) ? '0 : acc[j];  // ReLU when act!=0
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;  pe_state_q <= PE_IDLE;
      ready_q <= 1'b0;    full_q <= 1'b0;      act_q <= 1'b0;
      num_layers_q <= '0; num_in_q <= '0;      num_out_q <= '0;
      cnt_q <= '0;        pe_cnt_q <= '0;      mac_cnt_q <= '0;  wcol_q <= '0;
      wwr_q <= '0;        inwr_q <= '0;        inrd_q <= '0;
      outrd_q <= '0;      outwr_q <= '0;
      for (int i = 0; i < MAX_IN; i++) inbuf_q[i] <= '0;
      for (int j = 0; j < NUM_PE; j++) begin
        outbuf_q[j] <= '0;
        for (int k = 0; k < WDEP; k++) wmem_q[j][k] <= '0;
      end
    end else begin
      if (oe && !we) outrd_q <= (outrd_q == num_out_q) ? '0 : outrd_q + 5'd1;
      case (state_q)
        S_IDLE, S_DONE: if (we) begin
          state_q <= S_START; ready_q <= 1'b0; full_q <= 1'b0;
          cnt_q <= '0; pe_cnt_q <= '0; mac_cnt_q <= '0; wcol_q <= '0;
          wwr_q <= '0; inwr_q <= '0; inrd_q <= '0; outrd_q <= '0; outwr_q <= '0;
        end
        S_START: state_q <= S_CFG;
        S_CFG: if (!we) state_q <= S_IDLE;
        else begin
          // words 2 and 3 (hidden-layer sizes) are accepted but unused
          case (cnt_q)
            5'd0: num_layers_q <= data[1:0];
            5'd1: num_in_q     <= data[4:0];
            5'd4: num_out_q    <= (data > 32'(NUM_PE - 1)) ? 5'(NUM_PE - 1) : data[4:0];
            5'd5: act_q        <= |data;
            default: ;
          endcase
          if (cnt_q == 5'd5) begin
            cnt_q <= '0; state_q <= S_LOADW; pe_state_q <= PE_LOAD;
          end else cnt_q <= cnt_q + 5'd1;
        end
        S_LOADW: if (!we) begin
          state_q <= S_IDLE; pe_state_q <= PE_IDLE;
        end else begin
          wmem_q[pe_cnt_q[PW-1:0]][wcol_q] <= data;
          wwr_q <= wwr_q + 1'b1;
          cnt_q <= cnt_q + 5'd1;
          if (wcol_q == bias_idx) begin
            wcol_q <= '0;
            if (pe_cnt_q == num_out_q) begin
              state_q <= S_LOADIN; pe_state_q <= PE_MA; cnt_q <= '0;
            end else pe_cnt_q <= pe_cnt_q + 5'd1;
          end else wcol_q <= wcol_q + 6'd1;
        end
        S_LOADIN: if (!we) begin
          state_q <= S_IDLE; pe_state_q <= PE_IDLE;
        end else begin
          inbuf_q[inwr_q] <= data;
          inrd_q    <= inwr_q;
          inwr_q    <= inwr_q + 5'd1;
          mac_cnt_q <= mac_cnt_q + 6'd1;
          cnt_q     <= cnt_q + 5'd1;
          if (mac_cnt_q == 6'(num_in_q)) begin
            state_q <= S_BIAS; pe_state_q <= PE_BIAS;
          end
        end
        S_BIAS: begin
          state_q <= S_ACT; pe_state_q <= PE_ACT;
        end
        S_ACT: begin
          for (int j = 0; j < NUM_PE; j++)
            if (5'(j) <= num_out_q) outbuf_q[j] <= res[j];
          outwr_q <= num_out_q + 5'd1;
          state_q <= S_DONE; pe_state_q <= PE_IDLE;
          ready_q <= 1'b1;   full_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready           = ready_q;
  assign pe_state_r0     = pe_state_q;
  assign state_r         = state_q;
  assign num_layers_r    = num_layers_q;
  assign num_neurons_r3  = num_out_q;
  assign num_multadds    = 6'(num_in_q) + 6'd1;
  assign state_count_r   = cnt_q;
  assign multadd_count_r = mac_cnt_q;
  assign fp_mac_a        = data;
  assign fp_mac_b        = wmem_q[0][mac_cnt_q];
  assign fp_mac_output   = acc[0];
  assign counter         = pe_cnt_q;
  assign fp_mac_acc      = mac_en;
  assign ArrWgt_Rd       = AW'(mac_cnt_q);
  assign ArrWgt_Wr       = wwr_q;
  assign InBuf_Rd        = inrd_q;
  assign InBuf_Wr        = inwr_q;
  assign OutBuf_Rd       = outrd_q;
  assign OutBuf_Wr       = outwr_q;
  assign pe_oe_0         = act_en;
  assign InBuf_i0        = inbuf_q[0];
  assign ArrWeights_i0   = wmem_q[0][0];
  assign ArrWeights_i1   = wmem_q[0][1];
  assign OutBuf_i0       = outbuf_q[0];
  assign OutBuf_n_i0     = act_en ? res[0] : outbuf_q[0];
  assign OutBuf_Full     = full_q;
endmodule

// File: tb/tb_npu.sv
`timescale 1ns/1ps
module tb_npu;
  logic clk = 1'b0, rst = 1'b0, we = 1'b0, oe = 1'b0, drv = 1'b0;
  logic [31:0] dval = '0;
  wire  [31:0] data;
  assign data = drv ? dval : 'z;

  logic        ready, fp_mac_acc, pe_oe_0, OutBuf_Full;
  logic [2:0]  pe_state_r0;
  logic [3:0]  state_r;
  logic [1:0]  num_layers_r;
  logic [4:0]  num_neurons_r3, state_count_r, counter;
  logic [4:0]  InBuf_Rd, InBuf_Wr, OutBuf_Rd, OutBuf_Wr;
  logic [5:0]  num_multadds, multadd_count_r;
  logic [11:0] ArrWgt_Rd, ArrWgt_Wr;
  logic [31:0] fp_mac_a, fp_mac_b, fp_mac_output;
  logic [31:0] InBuf_i0, ArrWeights_i0, ArrWeights_i1, OutBuf_i0, OutBuf_n_i0;

  npu #(.NUM_PE(8), .MAX_IN(32), .WGT_DEPTH(4096)) dut (
    .clk(clk), .rst(rst), .we(we), .oe(oe), .data(data), .ready(ready),
    .pe_state_r0(pe_state_r0), .state_r(state_r), .num_layers_r(num_layers_r),
    .num_neurons_r3(num_neurons_r3), .num_multadds(num_multadds),
    .state_count_r(state_count_r), .multadd_count_r(multadd_count_r),
    .fp_mac_a(fp_mac_a), .fp_mac_b(fp_mac_b), .fp_mac_output(fp_mac_output),
    .counter(counter), .fp_mac_acc(fp_mac_acc), .ArrWgt_Rd(ArrWgt_Rd),
    .ArrWgt_Wr(ArrWgt_Wr), .InBuf_Rd(InBuf_Rd), .InBuf_Wr(InBuf_Wr),
    .OutBuf_Rd(OutBuf_Rd), .OutBuf_Wr(OutBuf_Wr), .pe_oe_0(pe_oe_0),
    .InBuf_i0(InBuf_i0), .ArrWeights_i0(ArrWeights_i0), .ArrWeights_i1(ArrWeights_i1),
    .OutBuf_i0(OutBuf_i0), .OutBuf_n_i0(OutBuf_n_i0), .OutBuf_Full(OutBuf_Full)
  );

  always #5 clk = ~clk;

  int n_run = 0, n_fail = 0;
  logic [31:0] seq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // start word (optional), START-cycle word, then the six config words
  task automatic hdr(input bit with_start, input logic [31:0] nin, nout, act);
    seq.delete();
    if (with_start) seq.push_back(32'h0);
    seq.push_back(32'h0);
    seq.push_back(32'h0); seq.push_back(nin); seq.push_back(32'h0);
    seq.push_back(32'h0); seq.push_back(nout); seq.push_back(act);
  endtask

  task automatic put(input logic [31:0] w);
    @(negedge clk); we = 1'b1; drv = 1'b1; dval = w;
  endtask

  task automatic play();
    foreach (seq[i]) put(seq[i]);
    @(negedge clk); we = 1'b0; drv = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] exp);
    oe = 1'b1; #1;
    chk(tag, data, exp);
    @(negedge clk);
  endtask

  // 10 weights of 0.5, given bias, 10 inputs of 1.0
  task automatic tx_half(input logic [31:0] act, input logic [31:0] bias);
    hdr(1'b1, 32'd9, 32'd0, act);
    repeat (10) seq.push_back(32'h0000_8000);
    seq.push_back(bias);
    repeat (10) seq.push_back(32'h0001_0000);
    play();
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'(state_r), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_pe_state", 32'(pe_state_r0), 32'd0);
    chk("rst_outrd", 32'(OutBuf_Rd), 32'd0);

    // single neuron: 10 * 0.5 * 1.0 + 1.0 = 6.0
    tx_half(32'd0, 32'h0001_0000);
    chk("tx1_ready", 32'(ready), 32'd1);
    chk("tx1_state", 32'(state_r), 32'd7);
    chk("tx1_full", 32'(OutBuf_Full), 32'd1);
    chk("tx1_multadds", 32'(num_multadds), 32'd10);
    chk("tx1_macs", 32'(multadd_count_r), 32'd10);
    chk("tx1_wgt_wr", 32'(ArrWgt_Wr), 32'd11);
    chk("tx1_in_wr", 32'(InBuf_Wr), 32'd10);
    chk("tx1_out_wr", 32'(OutBuf_Wr), 32'd1);
    chk("tx1_w0", ArrWeights_i0, 32'h0000_8000);
    chk("tx1_in0", InBuf_i0, 32'h0001_0000);
    rd("tx1_result", 32'h0006_0000);
    chk("tx1_rd_wrap", 32'(OutBuf_Rd), 32'd0);
    oe = 1'b0;

    // 5.0 - 16.0 = -11.0: ReLU clamps to 0, linear keeps it
    tx_half(32'd1, 32'hFFF0_0000);
    rd("tx2_relu", 32'h0000_0000);
    oe = 1'b0;
    tx_half(32'd0, 32'hFFF0_0000);
    rd("tx2_linear", 32'hFFF5_0000);
    oe = 1'b0;

    // we and oe together: we wins, the NPU must not drive the bus
    we = 1'b1; oe = 1'b1; drv = 1'b1; dval = 32'hA5A5_A5A5; #1;
    chk("we_oe_nodrive", data, 32'hA5A5_A5A5);
    @(negedge clk);
    oe = 1'b0;
    chk("b2b_state", 32'(state_r), 32'd1);
    chk("b2b_ready", 32'(ready), 32'd0);

    // two neurons: {1,2,b=0}.{3,1} = 5.0 ; {-1,0,b=0.5}.{3,1} = -2.5
    hdr(1'b0, 32'd1, 32'd1, 32'd0);
    seq.delete(0);  // START edge was already consumed by the we+oe cycle
    seq.push_front(32'h0);
    seq.delete(0);
    foreach (seq[i]) put(seq[i]);
    seq.delete();
    seq.push_back(32'h0001_0000); seq.push_back(32'h0002_0000); seq.push_back(32'h0);
    seq.push_back(32'hFFFF_0000); seq.push_back(32'h0);         seq.push_back(32'h0000_8000);
    seq.push_back(32'h0003_0000); seq.push_back(32'h0001_0000);
    play();
    repeat (5) @(negedge clk);
    chk("tx3_nout", 32'(num_neurons_r3), 32'd1);
    chk("tx3_acc0", fp_mac_output, 32'h0005_0000);
    rd("tx3_out0", 32'h0005_0000);
    rd("tx3_out1", 32'hFFFD_8000);
    chk("tx3_rd_wrap", 32'(OutBuf_Rd), 32'd0);
    oe = 1'b0;

    // num_out=31 clamps to 7; neuron j: 1.0*2.0 + j
    hdr(1'b1, 32'd0, 32'd31, 32'd0);
    for (int j = 0; j < 8; j++) begin
      seq.push_back(32'h0001_0000);
      seq.push_back(32'(j) << 16);
    end
    seq.push_back(32'h0002_0000);
    play();
    repeat (5) @(negedge clk);
    chk("clamp_nout", 32'(num_neurons_r3), 32'd7);
    for (int j = 0; j < 8; j++) rd($sformatf("clamp_out%0d", j), 32'(2 + j) << 16);
    chk("clamp_rd_wrap", 32'(OutBuf_Rd), 32'd0);
    oe = 1'b0;

    // we drops mid weight load: abort to IDLE
    hdr(1'b1, 32'd1, 32'd0, 32'd0);
    seq.push_back(32'h0001_0000); seq.push_back(32'h0001_0000);
    play();
    @(negedge clk);
    chk("abort_state", 32'(state_r), 32'd0);
    chk("abort_ready", 32'(ready), 32'd0);

    // reset in the middle of a load
    hdr(1'b1, 32'd3, 32'd0, 32'd0);
    seq.push_back(32'h0001_0000); seq.push_back(32'h0002_0000);
    foreach (seq[i]) put(seq[i]);
    rst = 1'b0; #1;
    chk("rst2_state", 32'(state_r), 32'd0);
    chk("rst2_ready", 32'(ready), 32'd0);
    chk("rst2_wgt_wr", 32'(ArrWgt_Wr), 32'd0);
    chk("rst2_cnt", 32'(state_count_r), 32'd0);
    chk("rst2_w0", ArrWeights_i0, 32'd0);
    we = 1'b0; oe = 1'b1; dval = 32'h5A5A_0F0F; #1;
    chk("rst2_nodrive", data, 32'h5A5A_0F0F);
    @(negedge clk);
    rst = 1'b1; oe = 1'b0; drv = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
